// File: rtl/serial_subtractor_if.sv
// Handshake/data bundle for serial_subtractor.
//   start, a, b, bin : request side, driven by the master
//   busy, done, diff, bout : status/result side, driven by the subtractor
interface serial_subtractor_if #(parameter int WIDTH = 4) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (output start, a, b, bin, input busy, done, diff, bout);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout);
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell plus a borrow flop,
// one result bit per clock, LSB first.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   s     : serial_subtractor_if.slave
//           start/a/b/bin sampled when start is accepted (IDLE or DONE)
//           busy high while shifting, done one-cycle pulse with diff/bout
//           diff = (a - b - bin) mod 2^WIDTH, bout = (a < b + bin)
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  s
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sa, sb, acc, diff_q;
  logic             br, bout_q;
  logic [CW-1:0]    cnt;
  logic             d, br_nx, last, accept;

  // Full-subtractor cell on the current LSBs.
  assign d      = sa[0] ^ sb[0] ^ br;
  assign br_nx  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
  assign last   = (cnt == CW'(WIDTH - 1));
  // A request in SHIFT is dropped, not queued.
  assign accept = s.start && (state != SHIFT);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (s.start) state_nx = SHIFT;
      SHIFT:   if (last)    state_nx = DONE;
      DONE:    state_nx = s.start ? SHIFT : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa     <= '0;
      sb     <= '0;
      acc    <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else if (accept) begin
      sa  <= s.a;
      sb  <= s.b;
      br  <= s.bin;
      cnt <= '0;
      acc <= '0;
    end else if (state == SHIFT) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      br  <= br_nx;
      // Result bits enter at the MSB so bit 0 lands in place after WIDTH shifts.
      acc <= {d, acc[WIDTH-1:1]};
      cnt <= cnt + CW'(1);
      if (last) begin
        diff_q <= {d, acc[WIDTH-1:1]};
        bout_q <= br_nx;
      end
    end
  end

  assign s.busy = (state == SHIFT);
  assign s.done = (state == DONE);
  assign s.diff = diff_q;
  assign s.bout = bout_q;
endmodule
